crc24_tx_framer: RTL and testbench

Byte-stream framer that sits directly downstream of the byte-wise CRC-24 generator stage. It accepts payload bytes with a last-byte marker and computes a running CRC-24 over the whole frame, using generator x^24+x^23+x^18+x^17+x^14+x^11+x^10+x^7+x^6+x^5+x^4+x^3+x+1. It forwards the payload and appends the three CRC bytes, MSB first. Valid/ready handshakes on both sides support backpressure toward the link serializer.

---
 rtl/crc24_pkg.sv | 33 +++
 rtl/crc24_byte_update.sv | 17 +
 rtl/crc24_tx_framer.sv | 106 ++++++++++
 tb/tb_crc24_tx_framer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc24_pkg.sv
// Shared CRC-24 definitions: generator/initial constants, framer state
// encoding and the byte-wise CRC update used by generator and checker stages.
package crc24_pkg;

    localparam logic [23:0] CRC24_POLY = 24'h864CFB;
    localparam logic [23:0] CRC24_INIT = 24'h000000;

    typedef enum logic [1:0] {
        DATA,
        CRC_HI,
        CRC_MID,
        CRC_LO
    } crc24_state_e;

    // MSB-first, non-reflected update of the running CRC by one byte
    function automatic logic [23:0] crc24_update(
        input logic [23:0] crc_in,
        input logic [7:0]  data,
        input logic [23:0] poly
    );
        logic [23:0] c;
        c = crc_in ^ {data, 16'h0000};
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[23]) begin
                c = {c[22:0], 1'b0} ^ poly;
            end else begin
                c = {c[22:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc24_byte_update.sv
// Combinational one-byte CRC-24 update stage.
module crc24_byte_update
    import crc24_pkg::*;
#(
    parameter logic [23:0] POLY = CRC24_POLY
) (
    input  logic [23:0] crc_in,
    input  logic [7:0]  data,
    output logic [23:0] crc_out
);

    // Fold one byte into the running remainder
    always_comb begin
        crc_out = crc24_update(crc_in, data, POLY);
    end

endmodule

// File: rtl/crc24_tx_framer.sv
// CRC-24 transmit framer: forwards payload bytes, then appends the three
// CRC bytes MSB first, with valid/ready handshakes on both sides.
// Optional macro CRC24_FINAL_XOR_EN inverts the emitted CRC bytes.
module crc24_tx_framer
    import crc24_pkg::*;
#(
    parameter logic [23:0] POLY = CRC24_POLY,
    parameter logic [23:0] INIT = CRC24_INIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       crc_busy
);

`ifdef CRC24_FINAL_XOR_EN
    localparam logic [23:0] EMIT_MASK = 24'hFFFFFF;
`else
    localparam logic [23:0] EMIT_MASK = 24'h000000;
`endif

    crc24_state_e state;
    logic [23:0]  crc;
    logic [23:0]  crc_next;
    logic [23:0]  crc_emit;
    logic         slot;
    logic         in_xfer;

    crc24_byte_update #(.POLY(POLY)) u_update (
        .crc_in  (crc),
        .data    (s_data),
        .crc_out (crc_next)
    );

    // Output register is free when empty or being drained this cycle
    always_comb begin
        slot     = !m_valid || m_ready;
        s_ready  = reset && (state == DATA) && slot;
        in_xfer  = s_valid && s_ready;
        crc_busy = (state != DATA);
        crc_emit = crc ^ EMIT_MASK;
    end

    // Framer state machine with registered output byte
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= DATA;
            crc     <= INIT;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                DATA: begin
                    if (in_xfer) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        crc     <= crc_next;
                        if (s_last) begin
                            state <= CRC_HI;
                        end
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                CRC_HI: begin
                    if (slot) begin
                        m_data  <= crc_emit[23:16];
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        state   <= CRC_MID;
                    end
                end
                CRC_MID: begin
                    if (slot) begin
                        m_data  <= crc_emit[15:8];
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        state   <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (slot) begin
                        m_data  <= crc_emit[7:0];
                        m_valid <= 1'b1;
                        m_last  <= 1'b1;
                        crc     <= INIT;
                        state   <= DATA;
                    end
                end
                default: begin
                    state <= DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc24_tx_framer.sv
// Bench for crc24_tx_framer: directed frames, random frames under random
// backpressure, and mid-frame reset, against a bit-serial CRC model.
module tb_crc24_tx_framer;

`ifdef CRC24_FINAL_XOR_EN
    localparam logic [23:0] MASK = 24'hFFFFFF;
`else
    localparam logic [23:0] MASK = 24'h000000;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       crc_busy;

    always #5 clock = ~clock;

    crc24_tx_framer dut (
        .clock    (clock),
        .reset    (reset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .crc_busy (crc_busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_in_cyc  = 0;
    int          first_in_cyc = 0;
    logic [8:0]  exp_q[$];
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_out   = '0;
    logic        in_x, out_x, rdy_seen, busy_seen, mvalid_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: bit-serial long division of the message by the generator
    function automatic logic [23:0] model_crc(input logic [7:0] p[$]);
        logic [23:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 24'h000000;
        foreach (p[i]) begin
            b = p[i];
            for (int k = 7; k >= 0; k--) begin
                fb = c[23] ^ b[k];
                c  = {c[22:0], 1'b0};
                if (fb) c = c ^ 24'h864CFB;
            end
        end
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] p[$], input logic [23:0] c);
        foreach (p[i]) exp_q.push_back({1'b0, p[i]});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
    endtask

    // Observe handshakes for the coming edge, score outputs, advance one clock
    task automatic cycle();
        logic [8:0] e;
        #1;
        in_x        = s_valid && s_ready;
        out_x       = m_valid && m_ready;
        rdy_seen    = s_ready;
        busy_seen   = crc_busy;
        mvalid_seen = m_valid;
        if (reset) begin
            if (prev_stall)
                check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_out});
            check("spurious_out", {31'd0, out_x && (exp_q.size() == 0)}, 32'd0);
            if (out_x && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_byte", {23'd0, m_last, m_data}, {23'd0, e});
            end
            if (in_x) begin
                if (first_in_cyc < 0) first_in_cyc = cyc;
                last_in_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_last, m_data};
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic feed(input logic [7:0] p[$], input bit rnd);
        int idx   = 0;
        int guard = 0;
        first_in_cyc = -1;
        while (idx < p.size() && guard < 4000) begin
            s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = p[idx];
            s_last  = (idx == p.size() - 1);
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            if (in_x) idx++;
            guard++;
        end
        check("feed_accepted", idx, p.size());
    endtask

    task automatic drain(input bit rnd);
        int guard = 0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        while (exp_q.size() > 0 && guard < 4000) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0]  p[$];
        logic [23:0] c;
        int          last1;

        // Reset held two cycles with s_valid asserted
        reset   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b1;
        m_ready = 1'b1;
        @(negedge clock);
        cycle();
        cycle();
        check("rst_m_valid", {31'd0, mvalid_seen}, 32'd0);
        check("rst_busy", {31'd0, busy_seen}, 32'd0);
        check("rst_s_ready", {31'd0, rdy_seen}, 32'd0);
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        cycle();
        check("post_rst_s_ready", {31'd0, rdy_seen}, 32'd1);
        check("post_rst_m_valid", {31'd0, mvalid_seen}, 32'd0);

        // Single-byte frame {01}
        c = 24'h864CFB ^ MASK;
        p = '{8'h01};
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
        feed(p, 1'b0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check("single_consecutive", {31'd0, out_x}, 32'd1);
            check("single_s_ready", {31'd0, rdy_seen}, {31'd0, k == 4});
            check("single_busy", {31'd0, busy_seen}, {31'd0, k != 4});
        end
        cycle();
        check("single_idle_m_valid", {31'd0, mvalid_seen}, 32'd0);
        check("single_queue_empty", exp_q.size(), 0);

        // Back-to-back frames {00,01} then {00}
        c = 24'h864CFB ^ MASK;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
        c = 24'h000000 ^ MASK;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
        p = '{8'h00, 8'h01};
        feed(p, 1'b0);
        last1 = last_in_cyc;
        p = '{8'h00};
        feed(p, 1'b0);
        check("next_frame_accept_gap", first_in_cyc - last1, 4);
        drain(1'b0);

        // Random frames under random backpressure
        for (int f = 0; f < 100; f++) begin
            int n;
            n = $urandom_range(1, 16);
            p = {};
            for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            push_frame(p, model_crc(p) ^ MASK);
            feed(p, 1'b1);
        end
        drain(1'b1);

        // Reset after the second byte of a 5-byte frame
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b0;
        s_data  = 8'hA0;
        exp_q.push_back({1'b0, 8'hA0});
        cycle();
        check("rst_mid_b0_acc", {31'd0, in_x}, 32'd1);
        s_data = 8'hA1;
        cycle();
        check("rst_mid_b1_acc", {31'd0, in_x}, 32'd1);
        reset   = 1'b0;
        s_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_mid_m_valid", {31'd0, mvalid_seen}, 32'd0);
        check("rst_mid_busy", {31'd0, busy_seen}, 32'd0);
        check("rst_mid_queue", exp_q.size(), 0);
        c = 24'h864CFB ^ MASK;
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, c[23:16]});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b1, c[7:0]});
        p = '{8'h01};
        feed(p, 1'b0);
        drain(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
